// File: rtl/key_conditioner.sv
// -----------------------------------------------------------------------------
// key_conditioner
//
// Turns raw, active-low, bouncing push-buttons into clean per-key events for
// the blink-rate/pattern controller. Each channel is fully independent and
// runs this chain:
//
//   key_n -> 2-flop synchronizer -> debouncer -> level register
//         -> press/release edge pulses -> hold-to-auto-repeat FSM
//
// Ports
//   clk           : system clock
//   rst           : asynchronous, active-high reset (clears all state)
//   key_n         : raw buttons, active-low, asynchronous to clk
//   pressed       : debounced level, 1 = key held
//   press_pulse   : one-cycle pulse in the first cycle pressed is 1
//   release_pulse : one-cycle pulse in the first cycle pressed is 0 again
//   fire_pulse    : press_pulse OR auto-repeat pulse, one cycle wide
//
// Timing
//   From the first clk edge that samples key_n low, pressed and press_pulse
//   rise exactly DEBOUNCE_CYCLES+2 edges later: two synchronizer stages feed
//   a debouncer that needs DEBOUNCE_CYCLES disagreeing cycles, and the
//   accepted level is then registered into pressed. Release is symmetric.
//   The first repeat follows press_pulse by REPEAT_DELAY cycles, further
//   repeats follow every REPEAT_RATE cycles while the key stays held.
//
// Parameter constraints
//   DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_RATE must all be >= 1, and
//   CNT_W must be wide enough to hold the largest of them.
// -----------------------------------------------------------------------------
module key_conditioner #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 6250000,
    parameter int CNT_W           = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] pressed,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] fire_pulse
);

    // Hold/repeat state of one channel.
    typedef enum logic [1:0] {
        ST_RELEASED  = 2'd0,
        ST_HOLD_WAIT = 2'd1,
        ST_REPEATING = 2'd2
    } chan_state_t;

    // Terminal counts. Counters are compared for equality against these and
    // cleared on reaching them, so they never run past them and cannot wrap.
    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = '0;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi = gi + 1) begin : g_chan

            // -----------------------------------------------------------------
            // Synchronizer. Both flops reset to 1 (released) so a key that is
            // already held while rst is high is only seen after rst drops,
            // which makes it look like a fresh press rather than a glitch.
            // -----------------------------------------------------------------
            logic sync_0_reg;
            logic sync_1_reg;
            logic s;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_0_reg <= 1'b1;
                    sync_1_reg <= 1'b1;
                end else begin
                    sync_0_reg <= key_n[gi];
                    sync_1_reg <= sync_0_reg;
                end
            end

            // Synchronized key, active-high.
            assign s = ~sync_1_reg;

            // -----------------------------------------------------------------
            // Debouncer. The counter tracks how long s has disagreed with the
            // accepted level; any agreement clears it, so only an unbroken run
            // of DEBOUNCE_CYCLES disagreeing cycles flips stable_reg.
            // -----------------------------------------------------------------
            logic             stable_reg;
            logic [CNT_W-1:0] db_cnt_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stable_reg <= 1'b0;
                    db_cnt_reg <= CNT_ZERO;
                end else if (s == stable_reg) begin
                    db_cnt_reg <= CNT_ZERO;
                end else if (db_cnt_reg == DB_LAST) begin
                    stable_reg <= ~stable_reg;
                    db_cnt_reg <= CNT_ZERO;
                end else begin
                    db_cnt_reg <= db_cnt_reg + CNT_ONE;
                end
            end

            // -----------------------------------------------------------------
            // Edge detection. pressed_reg is the registered copy of the
            // accepted level; comparing it with stable_reg tells us, one cycle
            // ahead, that pressed is about to change. The pulses are registered
            // on that same edge, so they line up with the first cycle of the
            // new pressed level. pressed_reg cannot be both 0 and 1, so press
            // and release events are mutually exclusive by construction.
            // -----------------------------------------------------------------
            logic pressed_reg;
            logic press_event;
            logic release_event;

            assign press_event   = stable_reg & ~pressed_reg;
            assign release_event = ~stable_reg & pressed_reg;

            // -----------------------------------------------------------------
            // Hold-to-repeat FSM. It enters HOLD_WAIT on the same edge that
            // raises press_pulse, so hold_cnt counts from that edge and the
            // first repeat lands exactly REPEAT_DELAY cycles after the press.
            // A release always wins over a coinciding terminal count.
            // -----------------------------------------------------------------
            chan_state_t      state_reg;
            chan_state_t      state_next;
            logic [CNT_W-1:0] hold_cnt_reg;
            logic [CNT_W-1:0] hold_cnt_next;
            logic             repeat_fire;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_reg    <= ST_RELEASED;
                    hold_cnt_reg <= CNT_ZERO;
                end else begin
                    state_reg    <= state_next;
                    hold_cnt_reg <= hold_cnt_next;
                end
            end

            always_comb begin
                state_next    = state_reg;
                hold_cnt_next = hold_cnt_reg;
                repeat_fire   = 1'b0;

                case (state_reg)
                    ST_RELEASED: begin
                        if (press_event) begin
                            state_next    = ST_HOLD_WAIT;
                            hold_cnt_next = CNT_ZERO;
                        end
                    end

                    ST_HOLD_WAIT: begin
                        if (release_event) begin
                            state_next    = ST_RELEASED;
                            hold_cnt_next = CNT_ZERO;
                        end else if (REPEAT_EN != 0) begin
                            if (hold_cnt_reg == DELAY_LAST) begin
                                repeat_fire   = 1'b1;
                                state_next    = ST_REPEATING;
                                hold_cnt_next = CNT_ZERO;
                            end else begin
                                hold_cnt_next = hold_cnt_reg + CNT_ONE;
                            end
                        end
                        // With repeat disabled the counter stays parked at 0
                        // and the channel simply waits here for the release.
                    end

                    ST_REPEATING: begin
                        if (release_event) begin
                            state_next    = ST_RELEASED;
                            hold_cnt_next = CNT_ZERO;
                        end else if (hold_cnt_reg == RATE_LAST) begin
                            repeat_fire   = 1'b1;
                            hold_cnt_next = CNT_ZERO;
                        end else begin
                            hold_cnt_next = hold_cnt_reg + CNT_ONE;
                        end
                    end

                    default: begin
                        state_next    = ST_RELEASED;
                        hold_cnt_next = CNT_ZERO;
                    end
                endcase
            end

            // -----------------------------------------------------------------
            // Output registers. Repeats only come from HOLD_WAIT/REPEATING and
            // a press only from RELEASED, so the two sources of fire_pulse can
            // never coincide.
            // -----------------------------------------------------------------
            logic press_pulse_reg;
            logic release_pulse_reg;
            logic fire_pulse_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pressed_reg       <= 1'b0;
                    press_pulse_reg   <= 1'b0;
                    release_pulse_reg <= 1'b0;
                    fire_pulse_reg    <= 1'b0;
                end else begin
                    pressed_reg       <= stable_reg;
                    press_pulse_reg   <= press_event;
                    release_pulse_reg <= release_event;
                    fire_pulse_reg    <= press_event | repeat_fire;
                end
            end

            assign pressed[gi]       = pressed_reg;
            assign press_pulse[gi]   = press_pulse_reg;
            assign release_pulse[gi] = release_pulse_reg;
            assign fire_pulse[gi]    = fire_pulse_reg;

        end
    endgenerate

endmodule

// File: tb/tb_key_conditioner.sv
// -----------------------------------------------------------------------------
// tb_key_conditioner
//
// Drives two key_conditioner instances from the same buttons: one with
// auto-repeat (DEBOUNCE 4, DELAY 10, RATE 3) and one with repeat disabled.
// Every stimulus step pushes the pulses it must cause (cycle, kind, channel)
// onto a scoreboard queue; a negedge monitor pops the matching entry for each
// pulse the DUTs produce and compares the cycle. Leftover entries at the end
// of a phase are missing pulses. Edges are counted in cyc; a key driven low
// while cyc == c is first sampled on edge c+1.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_key_conditioner;

    localparam int NK     = 4;
    localparam int DB     = 4;
    localparam int RDELAY = 10;
    localparam int RRATE  = 3;
    localparam int LAT    = DB + 2;

    // Pulse kinds in the scoreboard.
    localparam int K_PRESS   = 0;
    localparam int K_RELEASE = 1;
    localparam int K_FIRE    = 2;
    localparam int K_FIRE_NR = 3;

    logic          clk;
    logic          rst;
    logic [NK-1:0] key_n;
    logic [NK-1:0] pressed, press_pulse, release_pulse, fire_pulse;
    logic [NK-1:0] nr_pressed, nr_press_pulse, nr_release_pulse, nr_fire_pulse;

    typedef struct {
        int cyc;
        int kind;
        int ch;
    } ev_t;

    ev_t exp_q[$];
    int  cyc      = 0;
    int  n_checks = 0;
    int  n_fails  = 0;

    key_conditioner #(
        .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .REPEAT_EN(1),
        .REPEAT_DELAY(RDELAY), .REPEAT_RATE(RRATE), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .key_n(key_n),
        .pressed(pressed), .press_pulse(press_pulse),
        .release_pulse(release_pulse), .fire_pulse(fire_pulse)
    );

    key_conditioner #(
        .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .REPEAT_EN(0),
        .REPEAT_DELAY(RDELAY), .REPEAT_RATE(RRATE), .CNT_W(16)
    ) dut_norep (
        .clk(clk), .rst(rst), .key_n(key_n),
        .pressed(nr_pressed), .press_pulse(nr_press_pulse),
        .release_pulse(nr_release_pulse), .fire_pulse(nr_fire_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kind_name(input int k);
        case (k)
            K_PRESS:   return "press";
            K_RELEASE: return "release";
            K_FIRE:    return "fire";
            default:   return "fire_norep";
        endcase
    endfunction

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_ev(input int c, input int k, input int ch);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        e.ch   = ch;
        exp_q.push_back(e);
    endtask

    // Expected pulses of one hold: the key is first sampled low on edge ts;
    // the hold ends at edge cut (release accepted, or reset), and a repeat
    // falling on that edge is suppressed.
    task automatic expect_hold(input int ch, input int ts, input int cut, input bit with_release);
        int p;
        p = ts + LAT;
        push_ev(p, K_PRESS, ch);
        push_ev(p, K_FIRE, ch);
        push_ev(p, K_FIRE_NR, ch);
        for (int t = p + RDELAY; t < cut; t += RRATE)
            push_ev(t, K_FIRE, ch);
        if (with_release)
            push_ev(cut, K_RELEASE, ch);
    endtask

    task automatic observe(input int kind, input int ch);
        int idx;
        idx = -1;
        for (int k = 0; k < exp_q.size(); k++)
            if (idx < 0 && exp_q[k].kind == kind && exp_q[k].ch == ch)
                idx = k;
        if (idx < 0) begin
            check_val($sformatf("unexpected %s ch%0d at cycle", kind_name(kind), ch), cyc, -1);
        end else begin
            $display("cyc %0d: ch%0d %s (expected at %0d)", cyc, ch, kind_name(kind), exp_q[idx].cyc);
            check_val($sformatf("%s ch%0d cycle", kind_name(kind), ch), cyc, exp_q[idx].cyc);
            exp_q.delete(idx);
            if (kind == K_PRESS)
                check_val($sformatf("pressed ch%0d at press", ch), int'(pressed[ch]), 1);
            if (kind == K_RELEASE)
                check_val($sformatf("pressed ch%0d at release", ch), int'(pressed[ch]), 0);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < NK; i++) begin
            if (press_pulse[i])   observe(K_PRESS, i);
            if (release_pulse[i]) observe(K_RELEASE, i);
            if (fire_pulse[i])    observe(K_FIRE, i);
            if (nr_fire_pulse[i]) observe(K_FIRE_NR, i);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, " pressed"},         int'(pressed),        0);
        check_val({tag, " press_pulse"},     int'(press_pulse),    0);
        check_val({tag, " release_pulse"},   int'(release_pulse),  0);
        check_val({tag, " fire_pulse"},      int'(fire_pulse),     0);
        check_val({tag, " norep pressed"},   int'(nr_pressed),     0);
        check_val({tag, " norep fire"},      int'(nr_fire_pulse),  0);
    endtask

    task automatic drain(input string phase);
        step(12);
        for (int k = 0; k < exp_q.size(); k++)
            $display("  %s: still pending %s ch%0d at cycle %0d",
                     phase, kind_name(exp_q[k].kind), exp_q[k].ch, exp_q[k].cyc);
        check_val({phase, " pending events"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Hold the keys in mask low for 'hold' sampling edges, then release them.
    task automatic hold_keys(input logic [NK-1:0] mask, input int hold);
        int ts;
        ts = cyc + 1;
        for (int i = 0; i < NK; i++)
            if (mask[i]) expect_hold(i, ts, ts + hold + LAT, 1'b1);
        key_n = key_n & ~mask;
        step(hold);
        key_n = key_n | mask;
    endtask

    initial begin
        int ts;
        rst   = 1'b1;
        key_n = '1;

        // Reset state.
        step(3);
        check_all_zero("reset");
        rst = 1'b0;
        step(2);
        check_all_zero("after reset");

        // Clean press on key 0, 20 cycles; repeats only on the repeat DUT.
        hold_keys(4'b0001, 20);
        drain("clean press");

        // Bounce on key 1: 2 low / 2 high, five times, then a real hold.
        for (int k = 0; k < 5; k++) begin
            key_n[1] = 1'b0;
            step(2);
            check_val("bounce pressed[1]", int'(pressed[1]), 0);
            key_n[1] = 1'b1;
            step(2);
            check_val("bounce pressed[1]", int'(pressed[1]), 0);
        end
        hold_keys(4'b0010, 12);
        drain("bounce");

        // Auto-repeat on key 2 held 40 cycles; the terminal count coincides
        // with the release edge, where no repeat may appear.
        hold_keys(4'b0100, 40);
        drain("auto-repeat");

        // Keys 0 and 3 together, key 3 released after 2 cycles.
        ts = cyc + 1;
        expect_hold(0, ts, ts + 8 + LAT, 1'b1);
        key_n[0] = 1'b0;
        key_n[3] = 1'b0;
        step(2);
        key_n[3] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step(1);
            check_val("simultaneous pressed[3]", int'(pressed[3]), 0);
        end
        key_n[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step(1);
            check_val("simultaneous pressed[3]", int'(pressed[3]), 0);
        end
        drain("simultaneous");

        // Reset while key 0 is repeating; rst asserted just after edge ts+18.
        ts = cyc + 1;
        expect_hold(0, ts, ts + 19, 1'b0);
        key_n[0] = 1'b0;
        step(19);
        rst = 1'b1;
        #1;
        check_all_zero("reset mid-hold immediate");
        for (int k = 0; k < 3; k++) begin
            step(1);
            check_all_zero("reset mid-hold");
        end
        rst = 1'b0;
        hold_keys(4'b0001, 14);
        drain("reset mid-hold");

        // All keys held throughout reset: one fresh press per key afterwards.
        rst   = 1'b1;
        key_n = '0;
        #1;
        check_all_zero("reset keys held immediate");
        for (int k = 0; k < 4; k++) begin
            step(1);
            check_all_zero("reset keys held");
        end
        rst = 1'b0;
        hold_keys(4'b1111, 12);
        drain("held through reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
